// File: rtl/spi_master.sv
// SPI mode-0 master: byte-wide valid/ready transmit side, MSB-first shifting,
// programmable sclk half-period and chip-select setup/hold guard times.
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                           ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             last_q;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             accept;
  logic             sample;

  // tx_ready is only ever high in IDLE and NEXT, so accept implies one of those states.
  assign accept = tx_valid & tx_ready;
  assign sample = (state == S_HIGH) && (cnt == DIV_LAST);

  // Data-only shift registers carry no reset; their contents are always
  // fully overwritten before being observed.
  always_ff @(posedge clk) begin
    if (accept) tx_sr <= tx_data;
    if (sample) rx_sr <= {rx_sr[6:0], miso};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd7;
      last_q   <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_ready <= 1'b1;
          if (accept) begin
            last_q   <= tx_last;
            bit_idx  <= 3'd7;
            cs_n     <= 1'b0;
            mosi     <= tx_data[7];
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            state <= S_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt  <= '0;
            sclk <= 1'b0;
            if (bit_idx != 3'd0) begin
              bit_idx <= bit_idx - 3'd1;
              mosi    <= tx_sr[bit_idx - 3'd1];
              state   <= S_LOW;
            end else begin
              rx_data  <= {rx_sr[6:0], miso};
              rx_valid <= 1'b1;
              if (last_q) begin
                state <= S_HOLD;
              end else begin
                tx_ready <= 1'b1;
                state    <= S_NEXT;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            state <= S_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_NEXT: begin
          // Reusing LOW gives the new byte a full low phase before its first rise.
          if (accept) begin
            last_q   <= tx_last;
            bit_idx  <= 3'd7;
            mosi     <= tx_data[7];
            tx_ready <= 1'b0;
            cnt      <= '0;
            state    <= S_LOW;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt      <= '0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          cs_n     <= 1'b1;
          sclk     <= 1'b0;
          tx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default instance with loopback/slave miso, plus a
// fast-parameter instance; received bytes are checked through a scoreboard.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   vec = 0;
  int   miss = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // default-parameter instance
  logic       a_tx_valid = 1'b0;
  logic [7:0] a_tx_data = 8'h00;
  logic       a_tx_last = 1'b0;
  logic       a_tx_ready, a_rx_valid, a_busy, a_sclk, a_cs_n, a_mosi, a_miso;
  logic [7:0] a_rx_data;
  logic       loop_en = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] slave_sr = 8'h00;

  assign a_miso = loop_en ? a_mosi : slave_sr[7];

  spi_master u_a (
    .clk(clk), .rst_n(rst_n), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
    .tx_last(a_tx_last), .tx_ready(a_tx_ready), .rx_valid(a_rx_valid),
    .rx_data(a_rx_data), .busy(a_busy), .sclk(a_sclk), .cs_n(a_cs_n),
    .mosi(a_mosi), .miso(a_miso)
  );

  // fast instance
  logic       b_tx_valid = 1'b0;
  logic [7:0] b_tx_data = 8'h00;
  logic       b_tx_last = 1'b0;
  logic       b_tx_ready, b_rx_valid, b_busy, b_sclk, b_cs_n, b_mosi;
  logic [7:0] b_rx_data;

  spi_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
    .tx_last(b_tx_last), .tx_ready(b_tx_ready), .rx_valid(b_rx_valid),
    .rx_data(b_rx_data), .busy(b_busy), .sclk(b_sclk), .cs_n(b_cs_n),
    .mosi(b_mosi), .miso(b_mosi)
  );

  // mode-0 slave: MSB presented at cs_n fall, shifted on each sclk fall
  always @(negedge a_cs_n) slave_sr = slave_byte;
  always @(negedge a_sclk) if (!a_cs_n) slave_sr = {slave_sr[6:0], 1'b0};

  logic [7:0] exp_q[$];
  logic [7:0] a_rx_q[$];
  logic [7:0] b_rx_q[$];

  int a_rises = 0, a_cs_low = 0, a_cs_falls = 0, a_pulses = 0, a_viol = 0, a_rv_bad = 0;
  int a_period = 0, a_rise_cyc = 0;
  logic [7:0] a_mosi_cap = 8'h00;
  logic a_sclk_q = 1'b0, a_mosi_q = 1'b0, a_cs_n_q = 1'b1, a_rv_q = 1'b0;
  int b_rises = 0, b_cs_low = 0, b_pulses = 0, b_period = 0, b_rise_cyc = 0;
  logic b_sclk_q = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!a_sclk_q && a_sclk) begin
        a_rises++;
        a_mosi_cap = {a_mosi_cap[6:0], a_mosi};
        a_period = cyc - a_rise_cyc;
        a_rise_cyc = cyc;
      end
      if (a_sclk_q && a_sclk && (a_mosi !== a_mosi_q)) a_viol++;
      if (!a_cs_n) a_cs_low++;
      if (a_cs_n_q && !a_cs_n) a_cs_falls++;
      if (a_rx_valid) begin
        a_pulses++;
        a_rx_q.push_back(a_rx_data);
        if (a_sclk || a_rv_q) a_rv_bad++;
      end
      if (!b_sclk_q && b_sclk) begin
        b_rises++;
        b_period = cyc - b_rise_cyc;
        b_rise_cyc = cyc;
      end
      if (!b_cs_n) b_cs_low++;
      if (b_rx_valid) begin
        b_pulses++;
        b_rx_q.push_back(b_rx_data);
      end
    end
    a_sclk_q = a_sclk; a_mosi_q = a_mosi; a_cs_n_q = a_cs_n; a_rv_q = a_rx_valid;
    b_sclk_q = b_sclk;
  end

  task automatic send_a(input logic [7:0] d, input logic last);
    int n;
    @(negedge clk);
    a_tx_valid = 1'b1; a_tx_data = d; a_tx_last = last;
    n = 0;
    while (!a_tx_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      vec++; miss++;
      $display("FAIL send_a_timeout: tx_ready=%b required 1", a_tx_ready);
    end
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    @(negedge clk);
    while (a_busy && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      vec++; miss++;
      $display("FAIL wait_idle_timeout: busy=%b required 0", a_busy);
    end
    @(negedge clk);
  endtask

  task automatic wait_sclk_high_a();
    int n;
    n = 0;
    @(negedge clk);
    while (!a_sclk && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      vec++; miss++;
      $display("FAIL wait_sclk_timeout: sclk=%b required 1", a_sclk);
    end
  endtask

  task automatic pop_cmp_a(input string name);
    logic [7:0] e;
    vec++;
    if (exp_q.size() == 0 || a_rx_q.size() == 0) begin
      miss++;
      $display("FAIL %s: rx entries=%0d expected entries=%0d", name, a_rx_q.size(), exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (a_rx_q[0] !== e) begin
        miss++;
        $display("FAIL %s: rx_data=%h required %h", name, a_rx_q[0], e);
      end
      void'(a_rx_q.pop_front());
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vec++; if (a_cs_n !== 1'b1) begin miss++; $display("FAIL rst_cs_n: got %b want 1", a_cs_n); end
    vec++; if (a_sclk !== 1'b0) begin miss++; $display("FAIL rst_sclk: got %b want 0", a_sclk); end
    vec++; if (a_mosi !== 1'b0) begin miss++; $display("FAIL rst_mosi: got %b want 0", a_mosi); end
    vec++; if (a_tx_ready !== 1'b0) begin miss++; $display("FAIL rst_tx_ready: got %b want 0", a_tx_ready); end
    vec++; if (a_rx_valid !== 1'b0 || a_rx_data !== 8'h00) begin
      miss++; $display("FAIL rst_rx: got %b/%h want 0/00", a_rx_valid, a_rx_data); end
    vec++; if (a_busy !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++; if (a_tx_ready !== 1'b1 || b_tx_ready !== 1'b1) begin
      miss++; $display("FAIL rst_release_ready: got %b/%b want 1/1", a_tx_ready, b_tx_ready); end
  endtask

  task automatic test_single_loopback();
    int r0, c0, p0, v0, f0;
    loop_en = 1'b1;
    r0 = a_rises; c0 = a_cs_low; p0 = a_pulses; v0 = a_viol + a_rv_bad; f0 = a_cs_falls;
    send_a(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    wait_idle_a();
    vec++; if (a_rises - r0 != 8) begin miss++; $display("FAIL a5_rises: got %0d want 8", a_rises - r0); end
    vec++; if (a_cs_low - c0 != 64) begin miss++; $display("FAIL a5_cs_low: got %0d want 64", a_cs_low - c0); end
    vec++; if (a_mosi_cap !== 8'hA5) begin miss++; $display("FAIL a5_mosi_bits: got %b want 10100101", a_mosi_cap); end
    vec++; if (a_pulses - p0 != 1) begin miss++; $display("FAIL a5_pulses: got %0d want 1", a_pulses - p0); end
    vec++; if (a_period != 8) begin miss++; $display("FAIL a5_sclk_period: got %0d want 8", a_period); end
    vec++; if (a_viol + a_rv_bad - v0 != 0 || a_cs_falls - f0 != 1) begin
      miss++; $display("FAIL a5_timing: violations=%0d falls=%0d want 0/1", a_viol + a_rv_bad - v0, a_cs_falls - f0); end
    pop_cmp_a("a5_rx_data");
  endtask

  task automatic test_slave();
    int p0;
    loop_en = 1'b0;
    slave_byte = 8'h3C;
    p0 = a_pulses;
    send_a(8'h00, 1'b1);
    exp_q.push_back(8'h3C);
    wait_idle_a();
    vec++; if (a_pulses - p0 != 1) begin miss++; $display("FAIL slave_pulses: got %0d want 1", a_pulses - p0); end
    pop_cmp_a("slave_rx_data");
    loop_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int r0, p0, f0, bad, n;
    r0 = a_rises; p0 = a_pulses; f0 = a_cs_falls; bad = 0;
    send_a(8'h12, 1'b0);
    exp_q.push_back(8'h12);
    n = 0;
    @(negedge clk);
    while (!a_tx_ready && n < 500) begin @(negedge clk); n++; end
    vec++; if (n >= 500) begin miss++; $display("FAIL burst_next_timeout: tx_ready=%b want 1", a_tx_ready); end
    for (int i = 0; i < 10; i++) begin
      if (a_cs_n !== 1'b0 || a_busy !== 1'b1 || a_sclk !== 1'b0) bad++;
      @(negedge clk);
    end
    vec++; if (bad != 0) begin miss++; $display("FAIL burst_gap: bad cycles=%0d want 0", bad); end
    send_a(8'h34, 1'b1);
    exp_q.push_back(8'h34);
    wait_idle_a();
    vec++; if (a_rises - r0 != 16) begin miss++; $display("FAIL burst_rises: got %0d want 16", a_rises - r0); end
    vec++; if (a_pulses - p0 != 2) begin miss++; $display("FAIL burst_pulses: got %0d want 2", a_pulses - p0); end
    vec++; if (a_cs_falls - f0 != 1) begin miss++; $display("FAIL burst_cs_falls: got %0d want 1", a_cs_falls - f0); end
    pop_cmp_a("burst_rx0");
    pop_cmp_a("burst_rx1");
  endtask

  task automatic test_hold_valid();
    int r0, p0, f0, n;
    r0 = a_rises; p0 = a_pulses; f0 = a_cs_falls;
    send_a(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    wait_sclk_high_a();
    a_tx_valid = 1'b1; a_tx_data = 8'hFF; a_tx_last = 1'b1;
    exp_q.push_back(8'hFF);
    n = 0;
    while (!a_cs_n && n < 500) begin @(negedge clk); n++; end
    vec++; if (a_rises - r0 != 8 || a_pulses - p0 != 1) begin
      miss++; $display("FAIL hold_first_byte: rises=%0d pulses=%0d want 8/1", a_rises - r0, a_pulses - p0); end
    n = 0;
    while (!a_tx_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
    wait_idle_a();
    vec++; if (a_rises - r0 != 16 || a_cs_falls - f0 != 2) begin
      miss++; $display("FAIL hold_total: rises=%0d falls=%0d want 16/2", a_rises - r0, a_cs_falls - f0); end
    pop_cmp_a("hold_rx0");
    pop_cmp_a("hold_rx1");
  endtask

  task automatic test_reset_mid();
    int p0, r0;
    p0 = a_pulses;
    send_a(8'hC3, 1'b1);
    wait_sclk_high_a();
    rst_n = 1'b0;
    #1;
    vec++; if (a_sclk !== 1'b0 || a_cs_n !== 1'b1 || a_mosi !== 1'b0) begin
      miss++; $display("FAIL midrst_outputs: sclk=%b cs_n=%b mosi=%b want 0/1/0", a_sclk, a_cs_n, a_mosi); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++; if (a_busy !== 1'b0 || a_pulses != p0) begin
      miss++; $display("FAIL midrst_release: busy=%b pulses=%0d want 0/0", a_busy, a_pulses - p0); end
    r0 = a_rises;
    send_a(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    wait_idle_a();
    vec++; if (a_rises - r0 != 8 || a_mosi_cap !== 8'h5A) begin
      miss++; $display("FAIL midrst_restart: rises=%0d mosi=%h want 8/5a", a_rises - r0, a_mosi_cap); end
    pop_cmp_a("midrst_rx");
  endtask

  task automatic test_fast();
    int r0, c0, n;
    logic [7:0] e;
    r0 = b_rises; c0 = b_cs_low;
    @(negedge clk);
    b_tx_valid = 1'b1; b_tx_data = 8'h96; b_tx_last = 1'b1;
    e = 8'h96;
    @(posedge clk); #1;
    b_tx_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (b_busy && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    vec++; if (b_cs_low - c0 != 32) begin miss++; $display("FAIL fast_cs_low: got %0d want 32", b_cs_low - c0); end
    vec++; if (b_rises - r0 != 8 || b_period != 4) begin
      miss++; $display("FAIL fast_sclk: rises=%0d period=%0d want 8/4", b_rises - r0, b_period); end
    vec++;
    if (b_rx_q.size() != 1) begin
      miss++; $display("FAIL fast_rx_count: got %0d want 1", b_rx_q.size());
    end else if (b_rx_q[0] !== e) begin
      miss++; $display("FAIL fast_rx_data: got %h want %h", b_rx_q[0], e);
    end
  endtask

  initial begin
    test_reset();
    test_single_loopback();
    test_slave();
    test_back_to_back();
    test_hold_valid();
    test_reset_mid();
    test_fast();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
